body_integrator: RTL
====================

Name: body_integrator

Overview:
Physics integration stage that sits downstream of the per-frame force/acceleration pass. It connects to the register-file FSM access port (multi-address read/write strobes). When started, it walks bodies 1..NUM. For each body it reads position, velocity and acceleration, applies a semi-implicit Euler step in signed fixed point, and writes the new position and velocity back. It reports completion through a DONE level that the register file latches as its status bit.

Parameters:
MAX_BODIES, 10, upper clamp on body count; body indices are 1..MAX_BODIES.
DT_SHIFT, 4, timestep as an arithmetic right shift; dt = 2^-DT_SHIFT.
POS_BASE, 23, register index base for position X; body i, axis k is at POS_BASE + k*AXIS_STRIDE + i.
VEL_BASE, 53, register index base for velocity X; same layout as position.
ACC_BASE, 83, register index base for acceleration X; same layout as position.
AXIS_STRIDE, 10, register distance between the X, Y and Z banks.

Ports:
CLK  in  1  system clock, 50 MHz
RESET  in  1  synchronous, active-high reset
START  in  1  one-cycle request to integrate all bodies
NUM  in  7  number of bodies to process
BUSY  out  1  high while a pass is in progress
DONE  out  1  high from pass completion until the next accepted START
RE  out  2  read strobe: 0 = none, 1 = ADDR1-3 only, 3 = ADDR1-6
WE  out  2  write strobe, same encoding as RE
ADDR1..ADDR6  out  8 each  register indices
WDATA1..WDATA6  out  32 each  write data
RDATA1..RDATA6  in  32 each  read data; valid on the cycle after the cycle in which RE was driven

Behaviour:
- Reset values: BUSY=0, DONE=0, RE=0, WE=0, all ADDR=0, all WDATA=0, body index=1, FSM in IDLE.
- RESET asserted mid-pass: FSM returns to IDLE on the next edge. No further writes are issued. Partially updated bodies remain as written.
- FSM states: IDLE -> RD_PV -> CAP_PV -> RD_ACC -> CAP_ACC -> COMPUTE -> WRITE -> (back to RD_PV for the next body, or to FIN).
- IDLE: START=1 latches Nc = min(NUM, MAX_BODIES), sets index i=1, clears DONE, sets BUSY. If Nc=0, go straight to FIN.
- RD_PV: RE=3. ADDR1-3 = position X/Y/Z of body i; ADDR4-6 = velocity X/Y/Z of body i.
- CAP_PV: capture RDATA1-6 into p[3] and v[3]. RE=0.
- RD_ACC: RE=1. ADDR1-3 = acceleration X/Y/Z of body i.
- CAP_ACC: capture RDATA1-3 into a[3].
- COMPUTE, per axis, signed 32-bit two's complement: v' = v + (a >>> DT_SHIFT); p' = p + (v' >>> DT_SHIFT). Overflow wraps.
- WRITE: WE=3 for exactly one cycle. ADDR1-3 = position addresses with WDATA1-3 = p'; ADDR4-6 = velocity addresses with WDATA4-6 = v'. If i == Nc go to FIN; otherwise i++ and go to RD_PV.
- FIN: BUSY=0, DONE=1; go to IDLE. DONE holds until the next accepted START.
- Timing: 6 cycles per body. With START sampled at edge k, body n's WRITE cycle is k+6n and DONE rises at cycle k+6*Nc+1. For Nc=0, DONE rises at k+1.
- START while BUSY is ignored. START coincident with RESET is ignored.
- Acceleration registers are read only, never written. The caller is responsible for clearing them.
- RE and WE are never nonzero in the same cycle.
- Outside RD_PV, RD_ACC and WRITE, ADDR/WDATA hold their previous values and are don't-care.

Optional Feature:
Macro: BODY_INTEGRATOR_SATURATE_EN.
- Defined: each sum (v' and p') saturates to 0x7FFFFFFF or 0x80000000 on signed overflow.
- Undefined: plain two's-complement wrap.

Test Plan:
- Body 1: posX=1000, velX=32, accX=160, other axes 0, NUM=1, START -> one WE=3 cycle at k+6 with ADDR1=24, WDATA1=1002, ADDR4=54, WDATA4=42; DONE=1 at k+7.
- Negative rounding: posY=0, velY=0, accY=-17 -> v'=-2, p'=-1 (WDATA2=0xFFFFFFFF, WDATA5=0xFFFFFFFE).
- NUM=3 -> exactly 3 WE pulses with ADDR1 = 24, 25, 26 at k+6, k+12, k+18; DONE at k+19. NUM=12 -> clamped to 10 WE pulses.
- NUM=0 -> no RE/WE activity; DONE=1 at k+1, BUSY never high. A second START during BUSY -> pass length unchanged.
- RESET asserted in CAP_ACC of body 2 -> next cycle BUSY=0, DONE=0, RE=WE=0; no write to address 25.
- posX=0x7FFFFFFF, velX=16, accX=0 -> WDATA1=0x80000000 without the macro; WDATA1=0x7FFFFFFF with BODY_INTEGRATOR_SATURATE_EN.

Source files
------------

// File: rtl/body_integrator_if.sv
// Register-file access port used by the body integrator: multi-address read/write strobes.
// Latency: read data is returned on the cycle after the cycle in which RE is driven.
// Backpressure: none; the register file always accepts strobes.
interface body_integrator_if;
    logic [1:0]  RE;
    logic [1:0]  WE;
    logic [7:0]  ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6;
    logic [31:0] WDATA1, WDATA2, WDATA3, WDATA4, WDATA5, WDATA6;
    logic [31:0] RDATA1, RDATA2, RDATA3, RDATA4, RDATA5, RDATA6;

    modport master (
        output RE, WE,
        output ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6,
        output WDATA1, WDATA2, WDATA3, WDATA4, WDATA5, WDATA6,
        input  RDATA1, RDATA2, RDATA3, RDATA4, RDATA5, RDATA6
    );

    modport slave (
        input  RE, WE,
        input  ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6,
        input  WDATA1, WDATA2, WDATA3, WDATA4, WDATA5, WDATA6,
        output RDATA1, RDATA2, RDATA3, RDATA4, RDATA5, RDATA6
    );
endinterface

// File: rtl/body_integrator.sv
// Semi-implicit Euler step over bodies 1..NUM (clamped); optional saturation via BODY_INTEGRATOR_SATURATE_EN.
// Latency: 6 cycles per body; body n written at k+6n after START at edge k, DONE at k+6*Nc+1.
// Backpressure: none; START is ignored while a pass is in progress or during RESET.
module body_integrator #(
    parameter int MAX_BODIES  = 10,
    parameter int DT_SHIFT    = 4,
    parameter int POS_BASE    = 23,
    parameter int VEL_BASE    = 53,
    parameter int ACC_BASE    = 83,
    parameter int AXIS_STRIDE = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [6:0] NUM,
    output logic       BUSY,
    output logic       DONE,
    body_integrator_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, RD_PV, CAP_PV, RD_ACC, CAP_ACC, COMPUTE, WRITE, FIN
    } state_t;

    state_t             state;
    logic [6:0]         idx;
    logic [6:0]         nc;
    logic signed [31:0] p [3];
    logic signed [31:0] v [3];
    logic signed [31:0] a [3];
    logic signed [31:0] v_new [3];
    logic signed [31:0] p_new [3];
    logic [6:0]         num_clamped;

    assign num_clamped = (NUM > 7'(MAX_BODIES)) ? 7'(MAX_BODIES) : NUM;

    function automatic logic [7:0] reg_addr(input int base, input int axis, input logic [6:0] i);
        return 8'(base + axis * AXIS_STRIDE + int'(i));
    endfunction

    function automatic logic signed [31:0] add32(input logic signed [31:0] x, input logic signed [31:0] y);
        logic signed [31:0] s;
        s = x + y;
`ifdef BODY_INTEGRATOR_SATURATE_EN
        if (x[31] == y[31] && s[31] != x[31])
            s = x[31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
`endif
        return s;
    endfunction

    // Per-axis Euler update from the captured operands; used when leaving WRITE.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            v_new[k] = add32(v[k], a[k] >>> DT_SHIFT);
            p_new[k] = add32(p[k], v_new[k] >>> DT_SHIFT);
        end
    end

    // FSM with registered outputs: each state's strobes/addresses are registered at the edge
    // leaving that state, so they are visible during the following cycle. Read data therefore
    // arrives two states after the read state and is captured on leaving RD_ACC / COMPUTE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            idx       <= 7'd1;
            nc        <= 7'd0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            bus.RE    <= 2'd0;
            bus.WE    <= 2'd0;
            bus.ADDR1 <= 8'd0;  bus.ADDR2 <= 8'd0;  bus.ADDR3 <= 8'd0;
            bus.ADDR4 <= 8'd0;  bus.ADDR5 <= 8'd0;  bus.ADDR6 <= 8'd0;
            bus.WDATA1 <= 32'd0; bus.WDATA2 <= 32'd0; bus.WDATA3 <= 32'd0;
            bus.WDATA4 <= 32'd0; bus.WDATA5 <= 32'd0; bus.WDATA6 <= 32'd0;
            for (int k = 0; k < 3; k++) begin
                p[k] <= 32'sd0;
                v[k] <= 32'sd0;
                a[k] <= 32'sd0;
            end
        end else begin
            bus.RE <= 2'd0;
            bus.WE <= 2'd0;
            case (state)
                IDLE: begin
                    if (START) begin
                        nc   <= num_clamped;
                        idx  <= 7'd1;
                        DONE <= 1'b0;
                        if (num_clamped == 7'd0) begin
                            state <= FIN;
                        end else begin
                            BUSY  <= 1'b1;
                            state <= RD_PV;
                        end
                    end
                end
                RD_PV: begin
                    bus.RE    <= 2'd3;
                    bus.ADDR1 <= reg_addr(POS_BASE, 0, idx);
                    bus.ADDR2 <= reg_addr(POS_BASE, 1, idx);
                    bus.ADDR3 <= reg_addr(POS_BASE, 2, idx);
                    bus.ADDR4 <= reg_addr(VEL_BASE, 0, idx);
                    bus.ADDR5 <= reg_addr(VEL_BASE, 1, idx);
                    bus.ADDR6 <= reg_addr(VEL_BASE, 2, idx);
                    state     <= CAP_PV;
                end
                CAP_PV: begin
                    state <= RD_ACC;
                end
                RD_ACC: begin
                    p[0] <= bus.RDATA1;  p[1] <= bus.RDATA2;  p[2] <= bus.RDATA3;
                    v[0] <= bus.RDATA4;  v[1] <= bus.RDATA5;  v[2] <= bus.RDATA6;
                    bus.RE    <= 2'd1;
                    bus.ADDR1 <= reg_addr(ACC_BASE, 0, idx);
                    bus.ADDR2 <= reg_addr(ACC_BASE, 1, idx);
                    bus.ADDR3 <= reg_addr(ACC_BASE, 2, idx);
                    state     <= CAP_ACC;
                end
                CAP_ACC: begin
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    a[0] <= bus.RDATA1;  a[1] <= bus.RDATA2;  a[2] <= bus.RDATA3;
                    state <= WRITE;
                end
                WRITE: begin
                    bus.WE     <= 2'd3;
                    bus.ADDR1  <= reg_addr(POS_BASE, 0, idx);
                    bus.ADDR2  <= reg_addr(POS_BASE, 1, idx);
                    bus.ADDR3  <= reg_addr(POS_BASE, 2, idx);
                    bus.ADDR4  <= reg_addr(VEL_BASE, 0, idx);
                    bus.ADDR5  <= reg_addr(VEL_BASE, 1, idx);
                    bus.ADDR6  <= reg_addr(VEL_BASE, 2, idx);
                    bus.WDATA1 <= p_new[0];  bus.WDATA2 <= p_new[1];  bus.WDATA3 <= p_new[2];
                    bus.WDATA4 <= v_new[0];  bus.WDATA5 <= v_new[1];  bus.WDATA6 <= v_new[2];
                    if (idx == nc) begin
                        state <= FIN;
                    end else begin
                        idx   <= idx + 7'd1;
                        state <= RD_PV;
                    end
                end
                FIN: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
